// File: rtl/branch_predict_unit.sv
// Branch predictor: a direct-mapped BTB with per-entry saturating counters, looked up in IF and trained in EX.
// Optional macro BP_GSHARE_EN XORs a global history register into the lookup index.
module branch_predict_unit #(
    parameter int IDX_BITS = 5,
    parameter int CTR_BITS = 2,
    parameter int GHR_BITS = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         if_pc,
    output logic                if_pred_taken,
    output logic [31:0]         if_pred_target,
    output logic [IDX_BITS-1:0] if_pred_idx,
    input  logic                ex_valid,
    input  logic [31:0]         ex_pc,
    input  logic                ex_branch,
    input  logic                ex_jump,
    input  logic                ex_br_en,
    input  logic [31:0]         ex_target,
    input  logic                ex_pred_taken,
    input  logic [31:0]         ex_pred_target,
    input  logic [IDX_BITS-1:0] ex_pred_idx,
    output logic                misprediction,
    output logic [1:0]          predmux_sel,
    output logic [31:0]         branch_count,
    output logic [31:0]         mispredict_count
);

    localparam int ENTRIES = 2 ** IDX_BITS;
    localparam int TAG_W   = 30 - IDX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'(2 ** (CTR_BITS - 1) - 1);
    localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(2 ** (CTR_BITS - 1));
    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
    localparam logic [CTR_BITS-1:0] CTR_MIN = '0;
    localparam logic [CTR_BITS-1:0] CTR_ONE = CTR_BITS'(1);

    logic                r_valid   [ENTRIES];
    logic [TAG_W-1:0]    r_tag     [ENTRIES];
    logic [31:0]         r_target  [ENTRIES];
    logic                r_is_jump [ENTRIES];
    logic [CTR_BITS-1:0] r_ctr     [ENTRIES];
    logic [31:0]         r_branch_count;
    logic [31:0]         r_mispredict_count;

    logic [IDX_BITS-1:0] w_lu_idx;
    logic [TAG_W-1:0]    w_if_tag;
    logic [TAG_W-1:0]    w_ex_tag;
    logic                w_lu_hit;
    logic                w_ex_hit;
    logic                w_mispredict;
    logic [1:0]          w_sel;
    logic [IDX_BITS+3:0] w_unused_bits;

    assign w_if_tag      = if_pc[31:IDX_BITS+2];
    assign w_ex_tag      = ex_pc[31:IDX_BITS+2];
    assign w_unused_bits = {if_pc[1:0], ex_pc[IDX_BITS+1:0]};

`ifdef BP_GSHARE_EN
    logic [GHR_BITS-1:0] r_ghr;
    assign w_lu_idx = if_pc[IDX_BITS+1:2] ^ IDX_BITS'(r_ghr);

    always_ff @(posedge clk) begin
        if (rst)
            r_ghr <= '0;
        else if (ex_valid && ex_branch && !ex_jump)
            r_ghr <= {r_ghr[GHR_BITS-2:0], ex_br_en};
    end
`else
    localparam int UNUSED_GHR_BITS = GHR_BITS;
    assign w_lu_idx = if_pc[IDX_BITS+1:2];
`endif

    // Lookup reads stored state only, so a same-cycle update is seen next cycle.
    assign w_lu_hit       = r_valid[w_lu_idx] && (r_tag[w_lu_idx] == w_if_tag);
    assign if_pred_taken  = !rst && w_lu_hit && (r_is_jump[w_lu_idx] || r_ctr[w_lu_idx][CTR_BITS-1]);
    assign if_pred_target = if_pred_taken ? r_target[w_lu_idx] : 32'h0;
    assign if_pred_idx    = w_lu_idx;

    assign w_ex_hit = r_valid[ex_pred_idx] && (r_tag[ex_pred_idx] == w_ex_tag);

    always_comb begin
        w_mispredict = 1'b0;
        w_sel        = 2'd1;
        if (ex_valid && !rst) begin
            if (ex_jump) begin
                if (!ex_pred_taken || (ex_pred_target != ex_target)) begin
                    w_mispredict = 1'b1;
                    w_sel        = 2'd0;
                end
            end else if (ex_branch) begin
                if ((ex_pred_taken != ex_br_en) || (ex_br_en && (ex_pred_target != ex_target))) begin
                    w_mispredict = 1'b1;
                    w_sel        = ex_br_en ? 2'd0 : 2'd2;
                end
            end else if (ex_pred_taken) begin
                w_mispredict = 1'b1;
                w_sel        = 2'd2;
            end
        end
    end

    assign misprediction    = w_mispredict;
    assign predmux_sel      = w_sel;
    assign branch_count     = r_branch_count;
    assign mispredict_count = r_mispredict_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]   <= 1'b0;
                r_tag[i]     <= '0;
                r_target[i]  <= '0;
                r_is_jump[i] <= 1'b0;
                r_ctr[i]     <= CTR_WNT;
            end
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else if (ex_valid) begin
            if (ex_jump) begin
                r_valid[ex_pred_idx]   <= 1'b1;
                r_tag[ex_pred_idx]     <= w_ex_tag;
                r_target[ex_pred_idx]  <= ex_target;
                r_is_jump[ex_pred_idx] <= 1'b1;
                r_ctr[ex_pred_idx]     <= CTR_MAX;
            end else if (ex_branch) begin
                if (w_ex_hit) begin
                    if (ex_br_en) begin
                        r_target[ex_pred_idx] <= ex_target;
                        if (r_ctr[ex_pred_idx] != CTR_MAX)
                            r_ctr[ex_pred_idx] <= r_ctr[ex_pred_idx] + CTR_ONE;
                    end else if (r_ctr[ex_pred_idx] != CTR_MIN) begin
                        r_ctr[ex_pred_idx] <= r_ctr[ex_pred_idx] - CTR_ONE;
                    end
                end else if (ex_br_en) begin
                    r_valid[ex_pred_idx]   <= 1'b1;
                    r_tag[ex_pred_idx]     <= w_ex_tag;
                    r_target[ex_pred_idx]  <= ex_target;
                    r_is_jump[ex_pred_idx] <= 1'b0;
                    r_ctr[ex_pred_idx]     <= CTR_WT;
                end
            end else if (ex_pred_taken) begin
                // Non-control instruction predicted taken: drop the aliasing entry.
                r_valid[ex_pred_idx] <= 1'b0;
            end
            if (ex_branch || ex_jump)
                r_branch_count <= r_branch_count + 32'd1;
            if (w_mispredict)
                r_mispredict_count <= r_mispredict_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit (default parameters, BP_GSHARE_EN undefined).
module tb_branch_predict_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic [31:0] if_pred_target;
    logic [4:0]  if_pred_idx;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_branch;
    logic        ex_jump;
    logic        ex_br_en;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic [4:0]  ex_pred_idx;
    logic        misprediction;
    logic [1:0]  predmux_sel;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    int checks = 0;
    int errors = 0;

    branch_predict_unit dut (
        .clk(clk), .rst(rst), .if_pc(if_pc),
        .if_pred_taken(if_pred_taken), .if_pred_target(if_pred_target), .if_pred_idx(if_pred_idx),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_branch(ex_branch), .ex_jump(ex_jump),
        .ex_br_en(ex_br_en), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
        .ex_pred_target(ex_pred_target), .ex_pred_idx(ex_pred_idx),
        .misprediction(misprediction), .predmux_sel(predmux_sel),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic v, input logic [31:0] pc, input logic br, input logic jmp,
                          input logic en, input logic [31:0] tgt, input logic pt,
                          input logic [31:0] ptgt, input logic [4:0] pidx);
        ex_valid       = v;
        ex_pc          = pc;
        ex_branch      = br;
        ex_jump        = jmp;
        ex_br_en       = en;
        ex_target      = tgt;
        ex_pred_taken  = pt;
        ex_pred_target = ptgt;
        ex_pred_idx    = pidx;
    endtask

    task automatic idle();
        set_ex(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 5'd0);
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        if_pc = 32'h60;
        set_ex(1'b1, 32'h60, 1'b0, 1'b1, 1'b0, 32'h80, 1'b0, 32'h0, 5'd24);
        tick();
        tick();
        checks++; if ({misprediction, predmux_sel} !== 3'b001) begin errors++; $display("FAIL rst_outputs got %b exp 001", {misprediction, predmux_sel}); end
        rst = 1'b0;
        idle();
        tick();
        checks++; if (if_pred_taken !== 1'b0) begin errors++; $display("FAIL reset_taken got %b exp 0", if_pred_taken); end
        checks++; if (if_pred_target !== 32'h0) begin errors++; $display("FAIL reset_target got %h exp 0", if_pred_target); end
        checks++; if (if_pred_idx !== 5'd24) begin errors++; $display("FAIL reset_idx got %0d exp 24", if_pred_idx); end
        checks++; if ({branch_count, mispredict_count} !== 64'h0) begin errors++; $display("FAIL reset_counts got %0d/%0d exp 0/0", branch_count, mispredict_count); end
    endtask

    task automatic test_branch();
        if_pc = 32'h60;
        set_ex(1'b1, 32'h60, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0, 5'd24);
        #1;
        checks++; if ({misprediction, predmux_sel} !== 3'b100) begin errors++; $display("FAIL alloc_mis got %b exp 100", {misprediction, predmux_sel}); end
        checks++; if (if_pred_taken !== 1'b0) begin errors++; $display("FAIL alloc_no_bypass got %b exp 0", if_pred_taken); end
        tick(); idle(); #1;
        checks++; if ({if_pred_taken, if_pred_target} !== {1'b1, 32'h80}) begin errors++; $display("FAIL alloc_lookup got %b/%h exp 1/80", if_pred_taken, if_pred_target); end
        checks++; if ({branch_count, mispredict_count} !== {32'd1, 32'd1}) begin errors++; $display("FAIL alloc_counts got %0d/%0d exp 1/1", branch_count, mispredict_count); end

        set_ex(1'b1, 32'h60, 1'b1, 1'b0, 1'b0, 32'h64, 1'b1, 32'h80, 5'd24);
        #1;
        checks++; if ({misprediction, predmux_sel} !== 3'b110) begin errors++; $display("FAIL nt1_mis got %b exp 110", {misprediction, predmux_sel}); end
        tick(); idle(); #1;
        checks++; if ({if_pred_taken, if_pred_target} !== {1'b0, 32'h0}) begin errors++; $display("FAIL nt1_lookup got %b/%h exp 0/0", if_pred_taken, if_pred_target); end

        set_ex(1'b1, 32'h60, 1'b1, 1'b0, 1'b0, 32'h999, 1'b0, 32'h123, 5'd24);
        #1;
        checks++; if ({misprediction, predmux_sel} !== 3'b001) begin errors++; $display("FAIL nt2_nomis got %b exp 001", {misprediction, predmux_sel}); end
        tick();
        set_ex(1'b1, 32'h60, 1'b1, 1'b0, 1'b0, 32'h64, 1'b0, 32'h0, 5'd24);
        for (int i = 0; i < 3; i++) tick();

        set_ex(1'b1, 32'h60, 1'b1, 1'b0, 1'b1, 32'h84, 1'b0, 32'h0, 5'd24);
        #1;
        checks++; if ({misprediction, predmux_sel} !== 3'b100) begin errors++; $display("FAIL sat_lo_mis got %b exp 100", {misprediction, predmux_sel}); end
        tick(); idle(); #1;
        checks++; if (if_pred_taken !== 1'b0) begin errors++; $display("FAIL sat_lo_taken got %b exp 0", if_pred_taken); end
        set_ex(1'b1, 32'h60, 1'b1, 1'b0, 1'b1, 32'h84, 1'b0, 32'h0, 5'd24);
        tick(); idle(); #1;
        checks++; if ({if_pred_taken, if_pred_target} !== {1'b1, 32'h84}) begin errors++; $display("FAIL ctr_wt_lookup got %b/%h exp 1/84", if_pred_taken, if_pred_target); end

        set_ex(1'b1, 32'h60, 1'b1, 1'b0, 1'b1, 32'h84, 1'b1, 32'h84, 5'd24);
        #1;
        checks++; if ({misprediction, predmux_sel} !== 3'b001) begin errors++; $display("FAIL taken_ok got %b exp 001", {misprediction, predmux_sel}); end
        tick(); tick(); idle(); #1;
        checks++; if (if_pred_taken !== 1'b1) begin errors++; $display("FAIL sat_hi_taken got %b exp 1", if_pred_taken); end

        set_ex(1'b1, 32'h60, 1'b1, 1'b0, 1'b1, 32'h88, 1'b1, 32'h84, 5'd24);
        #1;
        checks++; if ({misprediction, predmux_sel} !== 3'b100) begin errors++; $display("FAIL tgt_mis got %b exp 100", {misprediction, predmux_sel}); end
        tick(); idle(); #1;
        checks++; if (if_pred_target !== 32'h88) begin errors++; $display("FAIL tgt_update got %h exp 88", if_pred_target); end
        checks++; if ({branch_count, mispredict_count} !== {32'd11, 32'd5}) begin errors++; $display("FAIL branch_counts got %0d/%0d exp 11/5", branch_count, mispredict_count); end

        set_ex(1'b1, 32'h160, 1'b1, 1'b0, 1'b0, 32'h1A0, 1'b0, 32'h0, 5'd24);
        tick(); idle(); #1;
        checks++; if ({if_pred_taken, if_pred_target} !== {1'b1, 32'h88}) begin errors++; $display("FAIL nt_miss_nowrite got %b/%h exp 1/88", if_pred_taken, if_pred_target); end
        set_ex(1'b1, 32'h160, 1'b1, 1'b0, 1'b1, 32'h1A0, 1'b0, 32'h0, 5'd24);
        tick(); idle(); #1;
        checks++; if (if_pred_taken !== 1'b0) begin errors++; $display("FAIL evict_old_tag got %b exp 0", if_pred_taken); end
        if_pc = 32'h160;
        #1;
        checks++; if ({if_pred_taken, if_pred_target} !== {1'b1, 32'h1A0}) begin errors++; $display("FAIL realloc_lookup got %b/%h exp 1/1a0", if_pred_taken, if_pred_target); end
        checks++; if ({branch_count, mispredict_count} !== {32'd13, 32'd6}) begin errors++; $display("FAIL realloc_counts got %0d/%0d exp 13/6", branch_count, mispredict_count); end
    endtask

    task automatic test_jump();
        if_pc = 32'h100;
        set_ex(1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 32'h200, 1'b0, 32'h0, 5'd0);
        #1;
        checks++; if ({misprediction, predmux_sel} !== 3'b100) begin errors++; $display("FAIL jal_mis got %b exp 100", {misprediction, predmux_sel}); end
        tick(); idle(); #1;
        checks++; if ({if_pred_taken, if_pred_target} !== {1'b1, 32'h200}) begin errors++; $display("FAIL jal_lookup got %b/%h exp 1/200", if_pred_taken, if_pred_target); end
        set_ex(1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 32'h300, 1'b1, 32'h200, 5'd0);
        #1;
        checks++; if ({misprediction, predmux_sel} !== 3'b100) begin errors++; $display("FAIL jalr_mis got %b exp 100", {misprediction, predmux_sel}); end
        tick(); idle(); #1;
        checks++; if (if_pred_target !== 32'h300) begin errors++; $display("FAIL jalr_target got %h exp 300", if_pred_target); end
        set_ex(1'b1, 32'h100, 1'b1, 1'b1, 1'b0, 32'h300, 1'b1, 32'h300, 5'd0);
        #1;
        checks++; if ({misprediction, predmux_sel} !== 3'b001) begin errors++; $display("FAIL jump_priority got %b exp 001", {misprediction, predmux_sel}); end
        tick(); idle(); #1;
        checks++; if ({branch_count, mispredict_count} !== {32'd16, 32'd8}) begin errors++; $display("FAIL jump_counts got %0d/%0d exp 16/8", branch_count, mispredict_count); end
    endtask

    task automatic test_alias();
        if_pc = 32'h0C;
        set_ex(1'b1, 32'h0C, 1'b0, 1'b1, 1'b0, 32'h40, 1'b0, 32'h0, 5'd3);
        tick(); idle(); #1;
        checks++; if ({if_pred_taken, if_pred_target} !== {1'b1, 32'h40}) begin errors++; $display("FAIL alias_setup got %b/%h exp 1/40", if_pred_taken, if_pred_target); end
        set_ex(1'b1, 32'h0C, 1'b0, 1'b0, 1'b0, 32'h10, 1'b1, 32'h40, 5'd3);
        #1;
        checks++; if ({misprediction, predmux_sel} !== 3'b110) begin errors++; $display("FAIL alias_mis got %b exp 110", {misprediction, predmux_sel}); end
        tick(); idle(); #1;
        checks++; if (if_pred_taken !== 1'b0) begin errors++; $display("FAIL alias_invalidate got %b exp 0", if_pred_taken); end
        checks++; if ({branch_count, mispredict_count} !== {32'd17, 32'd10}) begin errors++; $display("FAIL alias_counts got %0d/%0d exp 17/10", branch_count, mispredict_count); end
    endtask

    task automatic test_same_cycle();
        if_pc = 32'h0C;
        set_ex(1'b1, 32'h0C, 1'b0, 1'b1, 1'b0, 32'h50, 1'b0, 32'h0, 5'd3);
        #1;
        checks++; if (if_pred_taken !== 1'b0) begin errors++; $display("FAIL same_cycle_old_invalid got %b exp 0", if_pred_taken); end
        tick(); idle(); #1;
        checks++; if ({if_pred_taken, if_pred_target} !== {1'b1, 32'h50}) begin errors++; $display("FAIL same_cycle_next got %b/%h exp 1/50", if_pred_taken, if_pred_target); end
        set_ex(1'b1, 32'h0C, 1'b0, 1'b1, 1'b0, 32'h60, 1'b1, 32'h50, 5'd3);
        #1;
        checks++; if (if_pred_target !== 32'h50) begin errors++; $display("FAIL same_cycle_old_target got %h exp 50", if_pred_target); end
        tick(); idle(); #1;
        checks++; if (if_pred_target !== 32'h60) begin errors++; $display("FAIL same_cycle_new_target got %h exp 60", if_pred_target); end
        set_ex(1'b0, 32'h0C, 1'b0, 1'b1, 1'b0, 32'h70, 1'b0, 32'h0, 5'd3);
        #1;
        checks++; if ({misprediction, predmux_sel} !== 3'b001) begin errors++; $display("FAIL invalid_defaults got %b exp 001", {misprediction, predmux_sel}); end
        tick(); tick(); idle(); #1;
        checks++; if (if_pred_target !== 32'h60) begin errors++; $display("FAIL invalid_no_write got %h exp 60", if_pred_target); end
        checks++; if ({branch_count, mispredict_count} !== {32'd19, 32'd12}) begin errors++; $display("FAIL invalid_counts got %0d/%0d exp 19/12", branch_count, mispredict_count); end
    endtask

    task automatic test_mid_reset();
        if_pc = 32'h0C;
        set_ex(1'b1, 32'h0C, 1'b0, 1'b1, 1'b0, 32'h90, 1'b1, 32'h60, 5'd3);
        rst = 1'b1;
        #1;
        checks++; if ({misprediction, predmux_sel, if_pred_taken} !== 4'b0010) begin errors++; $display("FAIL mid_rst_outputs got %b exp 0010", {misprediction, predmux_sel, if_pred_taken}); end
        tick();
        rst = 1'b0;
        idle();
        #1;
        checks++; if (if_pred_taken !== 1'b0) begin errors++; $display("FAIL mid_rst_entry got %b exp 0", if_pred_taken); end
        checks++; if ({branch_count, mispredict_count} !== 64'h0) begin errors++; $display("FAIL mid_rst_counts got %0d/%0d exp 0/0", branch_count, mispredict_count); end
    endtask

    initial begin
        rst   = 1'b1;
        if_pc = 32'h0;
        idle();
        test_reset();
        test_branch();
        test_jump();
        test_alias();
        test_same_cycle();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
